// File: rtl/wb_b3_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_b3_burst_master
// Description : Wishbone B3 initiator. One command becomes a classic single
//               access or a registered-feedback incrementing burst (linear,
//               wrap-4/8/16). Write data comes from a valid/ready stream, read
//               data goes out on a valid-only stream. Each command ends with a
//               done pulse carrying an error flag.
// Options     : `define WB_MASTER_TIMEOUT_EN to build an 8-bit watchdog that
//               aborts a beat left unanswered for 255 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_b3_burst_master #(
    parameter int aw = 32,
    parameter int dw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // command
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [3:0]    cmd_len_i,
    input  logic [1:0]    cmd_bte_i,
    // write-data stream
    input  logic [dw-1:0] wr_dat_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    // read-data stream
    output logic [dw-1:0] rd_dat_o,
    output logic          rd_valid_o,
    // completion
    output logic          done_o,
    output logic          err_o,
    // Wishbone master
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    // Byte-address masks of the word-index field that wraps in each mode
    localparam logic [aw-1:0] c_MASK_LIN   = {aw{1'b1}};
    localparam logic [aw-1:0] c_MASK_WRAP4 = aw'(32'h0000_000C);
    localparam logic [aw-1:0] c_MASK_WRAP8 = aw'(32'h0000_001C);
    localparam logic [aw-1:0] c_MASK_WRP16 = aw'(32'h0000_003C);
    localparam logic [aw-1:0] c_WORD_ALIGN = ~aw'(3);

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [aw-1:0]   adr_q, adr_d;
    logic [1:0]      bte_q, bte_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            single_q, single_d;
    logic            cyc_q, cyc_d;
    logic            rd_valid_q, rd_valid_d;
    logic [dw-1:0]   rd_dat_q, rd_dat_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [aw-1:0]   w_wrap_mask;
    logic [aw-1:0]   w_adr_inc;
    logic [aw-1:0]   w_adr_next;
    logic            w_abort_rsp;
    logic            w_timeout;

    // Select which address bits are allowed to count for the latched burst type
    always_comb begin
        w_wrap_mask = c_MASK_LIN;
        case (bte_q)
            2'b01:   w_wrap_mask = c_MASK_WRAP4;
            2'b10:   w_wrap_mask = c_MASK_WRAP8;
            2'b11:   w_wrap_mask = c_MASK_WRP16;
            default: w_wrap_mask = c_MASK_LIN;
        endcase
    end

    // Wrapping: only the masked index field takes the incremented value, so the
    // carry out of that field is discarded
    assign w_adr_inc   = adr_q + aw'(4);
    assign w_adr_next  = (adr_q & ~w_wrap_mask) | (w_adr_inc & w_wrap_mask);
    assign w_abort_rsp = wb_err_i | wb_rty_i | w_timeout;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;

    assign w_timeout = (wdog_q == 8'hFF);

    // Watchdog counts unanswered strobe cycles; holds during write stalls
    always_comb begin
        wdog_d = 8'd0;
        if ((state_q == S_BUS) && (state_d == S_BUS)) begin
            if (wb_ack_i | wb_err_i | wb_rty_i)
                wdog_d = 8'd0;
            else if (wb_stb_o)
                wdog_d = wdog_q + 8'd1;
            else
                wdog_d = wdog_q;
        end
    end

    // Watchdog register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            wdog_q <= 8'd0;
        else
            wdog_q <= wdog_d;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state, beat bookkeeping and completion decisions
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        adr_d      = adr_q;
        bte_d      = bte_q;
        cnt_d      = cnt_q;
        single_d   = single_q;
        cyc_d      = cyc_q;
        rd_valid_d = 1'b0;
        rd_dat_d   = rd_dat_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d  = S_BUS;
                    we_d     = cmd_we_i;
                    adr_d    = cmd_adr_i & c_WORD_ALIGN;
                    bte_d    = cmd_bte_i;
                    cnt_d    = cmd_len_i;
                    single_d = (cmd_len_i == 4'd0);
                    cyc_d    = 1'b1;
                end
            end
            S_BUS: begin
                if (wb_stb_o && w_abort_rsp) begin
                    // Abort: the beat carries no data
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (wb_stb_o && wb_ack_i) begin
                    cnt_d = cnt_q - 4'd1;
                    adr_d = w_adr_next;
                    if (!we_q) begin
                        rd_valid_d = 1'b1;
                        rd_dat_d   = wb_dat_i;
                    end
                    if (cnt_q == 4'd0) begin
                        state_d = S_IDLE;
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any cycle without a done pulse
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            adr_q      <= '0;
            bte_q      <= 2'b00;
            cnt_q      <= 4'd0;
            single_q   <= 1'b0;
            cyc_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_dat_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            bte_q      <= bte_d;
            cnt_q      <= cnt_d;
            single_q   <= single_d;
            cyc_q      <= cyc_d;
            rd_valid_q <= rd_valid_d;
            rd_dat_q   <= rd_dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Write strobe and data follow the stream so a stall simply lowers stb
    assign wb_stb_o    = cyc_q & (we_q ? wr_valid_i : 1'b1);
    assign wb_dat_o    = (cyc_q & we_q) ? wr_dat_i : '0;
    assign wb_cyc_o    = cyc_q;
    assign wb_we_o     = cyc_q & we_q;
    assign wb_sel_o    = cyc_q ? 4'hF : 4'h0;
    assign wb_bte_o    = cyc_q ? bte_q : 2'b00;
    assign wb_adr_o    = adr_q;
    assign wb_cti_o    = (!cyc_q || single_q) ? 3'b000 :
                         (cnt_q != 4'd0)      ? 3'b010 : 3'b111;
    assign wr_ready_o  = wb_ack_i & wb_stb_o & wb_we_o;
    assign cmd_ready_o = (state_q == S_IDLE);
    assign rd_valid_o  = rd_valid_q;
    assign rd_dat_o    = rd_dat_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_b3_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_b3_burst_master
// Description : Directed self-checking bench for wb_b3_burst_master. The slave
//               answers combinationally with data 0xD000_0000 | address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_b3_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [3:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [31:0] wr_dat = '0;
    logic        wr_valid = 1'b0;
    logic        ack_en = 1'b0, err_en = 1'b0;

    logic        cmd_ready, wr_ready, rd_valid, done, err;
    logic [31:0] rd_dat, wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign wb_ack   = wb_stb & ack_en;
    assign wb_err   = wb_stb & err_en;
    assign wb_rty   = 1'b0;
    assign wb_dat_i = 32'hD000_0000 | wb_adr;

    wb_b3_burst_master dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte),
        .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_dat_o(rd_dat), .rd_valid_o(rd_valid), .done_o(done), .err_o(err),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
    );

    // Present a command for one cycle; returns at the negedge of cycle N+1
    task automatic issue(input logic we, input logic [31:0] adr,
                         input logic [3:0] len, input logic [1:0] bte);
        @(negedge clk);
        cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        n_vec++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin n_err++; $display("FAIL rst_cyc_stb_we: got %b want 000", {wb_cyc, wb_stb, wb_we}); end
        n_vec++; if ({done, err, rd_valid, wr_ready} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {done, err, rd_valid, wr_ready}); end
        n_vec++; if ({wb_adr, wb_cti, wb_sel} !== 39'd0) begin n_err++; $display("FAIL rst_adr_cti_sel: got %h want 0", {wb_adr, wb_cti, wb_sel}); end
    endtask

    task automatic test_linear_write();
        wr_valid = 1'b1; wr_dat = 32'hA0; ack_en = 1'b1;
        issue(1'b1, 32'h100, 4'd3, 2'b00);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++; if (wb_adr !== 32'h100 + 32'(4*i)) begin n_err++; $display("FAIL lw_adr%0d: got %h want %h", i, wb_adr, 32'h100 + 32'(4*i)); end
            n_vec++; if (wb_cti !== ((i == 3) ? 3'b111 : 3'b010)) begin n_err++; $display("FAIL lw_cti%0d: got %b want %b", i, wb_cti, (i == 3) ? 3'b111 : 3'b010); end
            n_vec++; if (wb_dat_o !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL lw_dat%0d: got %h want %h", i, wb_dat_o, 32'hA0 + 32'(i)); end
            n_vec++; if ({wb_cyc, wb_stb, wb_we, wr_ready, wb_sel, done} !== 9'b1111_1111_0) begin n_err++; $display("FAIL lw_ctl%0d: got %b want 111111110", i, {wb_cyc, wb_stb, wb_we, wr_ready, wb_sel, done}); end
            @(posedge clk); #1 wr_dat = 32'hA0 + 32'(i + 1);
        end
        @(negedge clk);
        n_vec++; if ({wb_cyc, wb_stb, done, err, cmd_ready} !== 5'b00101) begin n_err++; $display("FAIL lw_end: got %b want 00101", {wb_cyc, wb_stb, done, err, cmd_ready}); end
        wr_valid = 1'b0; ack_en = 1'b0;
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL lw_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_wrap8_read();
        logic [31:0] exp_adr [8] = '{32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        ack_en = 1'b1;
        issue(1'b0, 32'h18, 4'd7, 2'b10);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                n_vec++; if (wb_adr !== exp_adr[i]) begin n_err++; $display("FAIL w8_adr%0d: got %h want %h", i, wb_adr, exp_adr[i]); end
                n_vec++; if ({wb_cti, wb_bte} !== {((i == 7) ? 3'b111 : 3'b010), 2'b10}) begin n_err++; $display("FAIL w8_cti_bte%0d: got %b", i, {wb_cti, wb_bte}); end
            end
            if (i > 0) begin
                n_vec++; if ({rd_valid, rd_dat} !== {1'b1, 32'hD000_0000 | exp_adr[i-1]}) begin n_err++; $display("FAIL w8_rd%0d: got %b/%h want 1/%h", i, rd_valid, rd_dat, 32'hD000_0000 | exp_adr[i-1]); end
            end else begin
                n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL w8_rd_early: got %b want 0", rd_valid); end
            end
            if (i < 8) @(negedge clk);
        end
        n_vec++; if ({wb_cyc, done, err} !== 3'b010) begin n_err++; $display("FAIL w8_end: got %b want 010", {wb_cyc, done, err}); end
        ack_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap4_read();
        logic [31:0] exp_adr [4] = '{32'h2C, 32'h20, 32'h24, 32'h28};
        ack_en = 1'b1;
        issue(1'b0, 32'h2E, 4'd3, 2'b01);   // low address bits must be dropped
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++; if (wb_adr !== exp_adr[i]) begin n_err++; $display("FAIL w4_adr%0d: got %h want %h", i, wb_adr, exp_adr[i]); end
        end
        @(negedge clk);
        n_vec++; if ({wb_cyc, done, err, rd_valid, rd_dat} !== {4'b0101, 32'hD000_0028}) begin n_err++; $display("FAIL w4_end: got %b/%h", {wb_cyc, done, err, rd_valid}, rd_dat); end
        ack_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        ack_en = 1'b0;
        issue(1'b0, 32'h40, 4'd0, 2'b00);
        n_vec++; if ({wb_cyc, wb_stb, wb_cti} !== 5'b11000) begin n_err++; $display("FAIL sr_start: got %b want 11000", {wb_cyc, wb_stb, wb_cti}); end
        @(negedge clk);
        n_vec++; if ({wb_cyc, rd_valid, done} !== 3'b100) begin n_err++; $display("FAIL sr_wait: got %b want 100", {wb_cyc, rd_valid, done}); end
        ack_en = 1'b1;
        @(negedge clk);
        n_vec++; if ({wb_cyc, wb_stb, rd_valid, done, err} !== 5'b00110) begin n_err++; $display("FAIL sr_end: got %b want 00110", {wb_cyc, wb_stb, rd_valid, done, err}); end
        n_vec++; if (rd_dat !== 32'hD000_0040) begin n_err++; $display("FAIL sr_dat: got %h want D0000040", rd_dat); end
        ack_en = 1'b0;
        @(negedge clk);
        n_vec++; if ({rd_valid, done} !== 2'b00) begin n_err++; $display("FAIL sr_once: got %b want 00", {rd_valid, done}); end
    endtask

    task automatic test_error_mid_burst();
        ack_en = 1'b1;
        issue(1'b0, 32'h200, 4'd3, 2'b00);
        n_vec++; if ({wb_adr, rd_valid} !== {32'h200, 1'b0}) begin n_err++; $display("FAIL er_beat0: got %h/%b", wb_adr, rd_valid); end
        @(posedge clk); #1 ack_en = 1'b0; err_en = 1'b1;
        @(negedge clk);
        n_vec++; if ({wb_cyc, rd_valid, done, wb_adr} !== {3'b110, 32'h204}) begin n_err++; $display("FAIL er_beat1: got %b/%h", {wb_cyc, rd_valid, done}, wb_adr); end
        @(posedge clk); #1 err_en = 1'b0;
        @(negedge clk);
        n_vec++; if ({wb_cyc, wb_stb, rd_valid, done, err, cmd_ready} !== 6'b000111) begin n_err++; $display("FAIL er_end: got %b want 000111", {wb_cyc, wb_stb, rd_valid, done, err, cmd_ready}); end
        @(negedge clk);
        n_vec++; if ({rd_valid, done, err} !== 3'b000) begin n_err++; $display("FAIL er_after: got %b want 000", {rd_valid, done, err}); end
    endtask

    task automatic test_write_stall();
        wr_valid = 1'b1; wr_dat = 32'hB0; ack_en = 1'b1;
        issue(1'b1, 32'h300, 4'd3, 2'b00);
        n_vec++; if ({wb_adr, wb_dat_o, wr_ready} !== {32'h300, 32'hB0, 1'b1}) begin n_err++; $display("FAIL ws_beat0: got %h/%h/%b", wb_adr, wb_dat_o, wr_ready); end
        @(posedge clk); #1 wr_valid = 1'b0; wr_dat = 32'hB1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_vec++; if ({wb_cyc, wb_stb, wr_ready, done, wb_adr} !== {4'b1000, 32'h304}) begin n_err++; $display("FAIL ws_stall%0d: got %b/%h", s, {wb_cyc, wb_stb, wr_ready, done}, wb_adr); end
        end
        @(posedge clk); #1 wr_valid = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if ({wb_stb, wr_ready, wb_adr, wb_dat_o} !== {2'b11, 32'h300 + 32'(4*i), 32'hB0 + 32'(i)}) begin n_err++; $display("FAIL ws_beat%0d: got %b/%h/%h", i, {wb_stb, wr_ready}, wb_adr, wb_dat_o); end
            @(posedge clk); #1 wr_dat = 32'hB0 + 32'(i + 1);
        end
        @(negedge clk);
        n_vec++; if ({wb_cyc, done, err} !== 3'b010) begin n_err++; $display("FAIL ws_end: got %b want 010", {wb_cyc, done, err}); end
        wr_valid = 1'b0; ack_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        ack_en = 1'b1;
        issue(1'b0, 32'h400, 4'd15, 2'b00);
        repeat (2) @(negedge clk);
        n_vec++; if (wb_cyc !== 1'b1) begin n_err++; $display("FAIL ar_busy: got %b want 1", wb_cyc); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({wb_cyc, wb_stb, wb_cti, rd_valid, done, cmd_ready} !== 8'b0000_0001) begin n_err++; $display("FAIL ar_async: got %b want 00000001", {wb_cyc, wb_stb, wb_cti, rd_valid, done, cmd_ready}); end
        @(negedge clk);
        rst = 1'b0; ack_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if ({wb_cyc, done, err, cmd_ready} !== 4'b0001) begin n_err++; $display("FAIL ar_after%0d: got %b want 0001", k, {wb_cyc, done, err, cmd_ready}); end
        end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int cyc_cnt = 0;
        ack_en = 1'b0; err_en = 1'b0;
        issue(1'b0, 32'h500, 4'd0, 2'b00);
        while (wb_cyc && cyc_cnt < 400) begin
            cyc_cnt++;
            @(negedge clk);
        end
        n_vec++; if (cyc_cnt !== 256) begin n_err++; $display("FAIL to_cycles: got %0d want 256", cyc_cnt); end
        n_vec++; if ({done, err, rd_valid} !== 3'b110) begin n_err++; $display("FAIL to_end: got %b want 110", {done, err, rd_valid}); end
        @(negedge clk);
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_linear_write();
        test_wrap8_read();
        test_wrap4_read();
        test_single_read();
        test_error_mid_burst();
        test_write_stall();
        test_async_reset();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
